mam_mem_arbiter: RTL and testbench

MAM_MEM_ARBITER -- requirements
Module: mam_mem_arbiter

---
 rtl/mam_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mam_mem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mam_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single burst-capable memory port.
// Define MAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (port 0 first).
module mam_mem_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                s_req_valid,
    output logic [1:0]                s_req_ready,
    input  logic [1:0]                s_req_rw,
    input  logic [1:0]                s_req_burst,
    input  logic [2*ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [27:0]               s_req_beats,
    input  logic [1:0]                s_write_valid,
    output logic [1:0]                s_write_ready,
    input  logic [2*DATA_WIDTH-1:0]   s_write_data,
    input  logic [2*DATA_WIDTH/8-1:0] s_write_strb,
    output logic [1:0]                s_read_valid,
    input  logic [1:0]                s_read_ready,
    output logic [DATA_WIDTH-1:0]     s_read_data,
    output logic                      m_req_valid,
    input  logic                      m_req_ready,
    output logic                      m_req_rw,
    output logic [ADDR_WIDTH-1:0]     m_req_addr,
    output logic                      m_req_burst,
    output logic [13:0]               m_req_beats,
    output logic                      m_write_valid,
    output logic [DATA_WIDTH-1:0]     m_write_data,
    output logic [DATA_WIDTH/8-1:0]   m_write_strb,
    input  logic                      m_write_ready,
    input  logic                      m_read_valid,
    input  logic [DATA_WIDTH-1:0]     m_read_data,
    output logic                      m_read_ready,
    output logic [1:0]                grant,
    output logic                      busy
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WRITE, ST_READ} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_grant;
    logic [1:0]  w_grant_nxt;
    logic [13:0] r_cnt;
    logic [13:0] w_cnt_nxt;
    logic        w_done;
    logic        w_g;
    logic        w_winner;
    logic        w_req_hs;
    logic        w_req_burst;
    logic [13:0] w_req_beats;

    assign w_g         = r_grant[1];
    assign w_req_burst = s_req_burst[w_g];
    assign w_req_beats = w_g ? s_req_beats[27:14] : s_req_beats[13:0];
    assign w_req_hs    = s_req_valid[w_g] & m_req_ready;

`ifdef MAM_ARB_FIXED_PRIO_EN
    assign w_winner = ~s_req_valid[0];
`else
    // Index of the requester served most recently; reset value makes port 0 win first.
    logic r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (w_done) begin
            r_last <= w_g;
        end
    end

    assign w_winner = (&s_req_valid) ? ~r_last : s_req_valid[1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
            r_cnt   <= 14'd0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_cnt_nxt     = r_cnt;
        w_done        = 1'b0;
        s_req_ready   = 2'b00;
        s_write_ready = 2'b00;
        s_read_valid  = 2'b00;
        s_read_data   = '0;
        m_req_valid   = 1'b0;
        m_req_rw      = 1'b0;
        m_req_addr    = '0;
        m_req_burst   = 1'b0;
        m_req_beats   = 14'd0;
        m_write_valid = 1'b0;
        m_write_data  = '0;
        m_write_strb  = '0;
        m_read_ready  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (|s_req_valid) begin
                    w_grant_nxt = w_winner ? 2'b10 : 2'b01;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                m_req_valid       = s_req_valid[w_g];
                m_req_rw          = s_req_rw[w_g];
                m_req_addr        = w_g ? s_req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                        : s_req_addr[0 +: ADDR_WIDTH];
                m_req_burst       = w_req_burst;
                m_req_beats       = w_req_beats;
                s_req_ready[w_g]  = m_req_ready;
                if (w_req_hs) begin
                    w_cnt_nxt = w_req_burst ? w_req_beats : 14'd1;
                    // A zero-length burst has no data phase at all.
                    if (w_req_burst && (w_req_beats == 14'd0)) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = s_req_rw[w_g] ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                m_write_valid      = s_write_valid[w_g];
                m_write_data       = w_g ? s_write_data[DATA_WIDTH +: DATA_WIDTH]
                                         : s_write_data[0 +: DATA_WIDTH];
                m_write_strb       = w_g ? s_write_strb[STRB_W +: STRB_W]
                                         : s_write_strb[0 +: STRB_W];
                s_write_ready[w_g] = m_write_ready;
                if (s_write_valid[w_g] && m_write_ready) begin
                    w_cnt_nxt = r_cnt - 14'd1;
                    w_done    = (r_cnt == 14'd1);
                end
            end
            ST_READ: begin
                s_read_valid[w_g] = m_read_valid;
                s_read_data       = m_read_data;
                m_read_ready      = s_read_ready[w_g];
                if (m_read_valid && s_read_ready[w_g]) begin
                    w_cnt_nxt = r_cnt - 14'd1;
                    w_done    = (r_cnt == 14'd1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_done) begin
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'b00;
        end
    end
endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Scoreboard bench for mam_mem_arbiter: a bus model drives both requesters and the
// memory, expected requests/beats are queued up front and a negedge monitor checks them.
module tb_mam_mem_arbiter;
    localparam int DW = 16;
    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic [1:0]    s_req_valid, s_req_ready, s_req_rw, s_req_burst;
    logic [2*AW-1:0] s_req_addr;
    logic [27:0]   s_req_beats;
    logic [1:0]    s_write_valid, s_write_ready;
    logic [2*DW-1:0] s_write_data;
    logic [3:0]    s_write_strb;
    logic [1:0]    s_read_valid, s_read_ready;
    logic [DW-1:0] s_read_data;
    logic          m_req_valid, m_req_ready, m_req_rw, m_req_burst;
    logic [AW-1:0] m_req_addr;
    logic [13:0]   m_req_beats;
    logic          m_write_valid, m_write_ready;
    logic [DW-1:0] m_write_data;
    logic [1:0]    m_write_strb;
    logic          m_read_valid, m_read_ready;
    logic [DW-1:0] m_read_data;
    logic [1:0]    grant;
    logic          busy;

    mam_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_rw(s_req_rw),
        .s_req_burst(s_req_burst), .s_req_addr(s_req_addr), .s_req_beats(s_req_beats),
        .s_write_valid(s_write_valid), .s_write_ready(s_write_ready),
        .s_write_data(s_write_data), .s_write_strb(s_write_strb),
        .s_read_valid(s_read_valid), .s_read_ready(s_read_ready), .s_read_data(s_read_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_rw(m_req_rw),
        .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
        .m_write_valid(m_write_valid), .m_write_data(m_write_data),
        .m_write_strb(m_write_strb), .m_write_ready(m_write_ready),
        .m_read_valid(m_read_valid), .m_read_data(m_read_data), .m_read_ready(m_read_ready),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic        rw;
        logic        burst;
        logic [31:0] addr;
        logic [13:0] beats;
        logic [15:0] base;
        logic [1:0]  strb;
    } tx_t;

    typedef struct packed {
        logic        port;
        logic [15:0] data;
        logic [1:0]  strb;
    } beat_t;

    tx_t   stim_q[$];
    tx_t   exp_req_q[$];
    beat_t exp_wr_q[$];
    beat_t exp_rd_q[$];

    // monitor-owned
    int    total = 0;
    int    bad = 0;
    bit    end_ack = 0;
    int    exp_left = 0;
    bit    idle_next = 0;
    bit    lat_pend = 0;
    tx_t   mon_e;
    beat_t mon_b;

    // stimulus-owned
    bit          end_req = 0;
    int          tmo = 0;
    tx_t         cur[2];
    tx_t         wtx[2];
    bit          have[2];
    int          wr_left[2];
    int          wr_idx[2];
    int          mem_rd_left;
    logic [15:0] mem_rd_data;
    int          stall;
    int          wr_hs;

    function automatic logic [1:0] onehot(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_outputs_zero",
                  {s_req_ready, s_write_ready, s_read_valid, s_read_data, m_req_valid, m_req_rw,
                   m_req_addr, m_req_burst, m_req_beats, m_write_valid, m_write_data,
                   m_write_strb, m_read_ready, grant, busy}, 128'd0);
            exp_req_q.delete();
            exp_wr_q.delete();
            exp_rd_q.delete();
            exp_left  = 0;
            idle_next = 0;
            lat_pend  = 0;
        end else begin
            if (lat_pend) begin
                check("req_latency_busy_mreqvalid", {busy, m_req_valid}, 2'b11);
                lat_pend = 0;
            end
            if (idle_next) begin
                check("idle_after_last_beat_busy_grant", {busy, grant}, 3'b000);
                idle_next = 0;
            end
            if (!busy && (|s_req_valid)) lat_pend = 1;
            if (busy)
                check("nongranted_isolation", (s_req_ready | s_write_ready | s_read_valid) & ~grant, 2'b00);
            if (m_req_valid && m_req_ready) begin
                check("req_expected", exp_req_q.size() > 0, 1'b1);
                if (exp_req_q.size() > 0) begin
                    mon_e = exp_req_q.pop_front();
                    check("req_grant_rw_addr_burst_beats",
                          {grant, m_req_rw, m_req_addr, m_req_burst, m_req_beats},
                          {onehot(mon_e.port), mon_e.rw, mon_e.addr, mon_e.burst, mon_e.beats});
                    exp_left = mon_e.burst ? int'(mon_e.beats) : 1;
                    if (exp_left == 0) idle_next = 1;
                end
            end
            if (m_write_valid && m_write_ready) begin
                check("wr_expected", exp_wr_q.size() > 0, 1'b1);
                if (exp_wr_q.size() > 0) begin
                    mon_b = exp_wr_q.pop_front();
                    check("wr_grant_data_strb", {grant, m_write_data, m_write_strb},
                          {onehot(mon_b.port), mon_b.data, mon_b.strb});
                end
                exp_left--;
                if (exp_left == 0) idle_next = 1;
            end
            if (|(s_read_valid & s_read_ready)) begin
                check("rd_expected", exp_rd_q.size() > 0, 1'b1);
                if (exp_rd_q.size() > 0) begin
                    mon_b = exp_rd_q.pop_front();
                    check("rd_valid_data", {s_read_valid, s_read_data},
                          {onehot(mon_b.port), mon_b.data});
                end
                exp_left--;
                if (exp_left == 0) idle_next = 1;
            end
            if (end_req && !end_ack) begin
                check("leftover_req", exp_req_q.size(), 0);
                check("leftover_wr", exp_wr_q.size(), 0);
                check("leftover_rd", exp_rd_q.size(), 0);
                check("run_timeouts", tmo, 0);
                end_ack = 1;
            end
        end
    end

    function automatic tx_t mk(input logic port, input logic rw, input logic burst,
                               input logic [31:0] addr, input logic [13:0] beats,
                               input logic [15:0] base, input logic [1:0] strb);
        tx_t t;
        t.port = port; t.rw = rw; t.burst = burst; t.addr = addr;
        t.beats = beats; t.base = base; t.strb = strb;
        return t;
    endfunction

    task automatic expect_tx(input tx_t t, input logic [15:0] rd_base);
        int n;
        exp_req_q.push_back(t);
        n = t.burst ? int'(t.beats) : 1;
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.port = t.port;
            b.strb = t.strb;
            b.data = t.rw ? (t.base + 16'(k)) : (rd_base + 16'(k));
            if (t.rw) exp_wr_q.push_back(b);
            else      exp_rd_q.push_back(b);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            s_req_valid[p]          = have[p];
            s_req_rw[p]             = cur[p].rw;
            s_req_burst[p]          = cur[p].burst;
            s_req_addr[p*AW +: AW]  = cur[p].addr;
            s_req_beats[p*14 +: 14] = cur[p].beats;
            s_write_valid[p]        = (wr_left[p] > 0);
            s_write_data[p*DW +: DW] = wtx[p].base + 16'(wr_idx[p]);
            s_write_strb[p*2 +: 2]  = wtx[p].strb;
        end
        m_write_ready = (stall == 0);
        m_read_valid  = (mem_rd_left > 0);
        m_read_data   = mem_rd_data;
    endtask

    task automatic clear_bfm();
        stim_q.delete();
        for (int p = 0; p < 2; p++) begin
            cur[p] = '0; wtx[p] = '0; have[p] = 0; wr_left[p] = 0; wr_idx[p] = 0;
        end
        mem_rd_left = 0; mem_rd_data = 16'h0; stall = 0; wr_hs = 0;
    endtask

    task automatic load_next(input int p);
        for (int i = 0; i < stim_q.size(); i++) begin
            if (int'(stim_q[i].port) == p) begin
                cur[p]  = stim_q[i];
                have[p] = 1;
                stim_q.delete(i);
                return;
            end
        end
    endtask

    task automatic cycle_step();
        logic [1:0]  hs_req, hs_wr;
        logic        mreq_hs, mreq_rw, mreq_burst, mrd_hs;
        logic [13:0] mreq_beats;
        @(negedge clk);
        hs_req     = s_req_valid & s_req_ready;
        hs_wr      = s_write_valid & s_write_ready;
        mreq_hs    = m_req_valid & m_req_ready;
        mreq_rw    = m_req_rw;
        mreq_burst = m_req_burst;
        mreq_beats = m_req_beats;
        mrd_hs     = m_read_valid & m_read_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (hs_req[p]) begin
                have[p] = 0;
                if (cur[p].rw) begin
                    wtx[p]     = cur[p];
                    wr_left[p] = cur[p].burst ? int'(cur[p].beats) : 1;
                    wr_idx[p]  = 0;
                end
            end
            if (hs_wr[p]) begin
                wr_idx[p]++;
                wr_left[p]--;
                wr_hs++;
            end
            if (!have[p]) load_next(p);
        end
        if (mrd_hs) begin
            mem_rd_left--;
            mem_rd_data++;
        end
        if (mreq_hs && !mreq_rw) mem_rd_left = mreq_burst ? int'(mreq_beats) : 1;
        if (stall > 0) stall--;
        drive();
    endtask

    function automatic bit all_idle();
        return (stim_q.size() == 0) && !have[0] && !have[1] && (wr_left[0] == 0) &&
               (wr_left[1] == 0) && (mem_rd_left == 0) && !busy;
    endfunction

    task automatic run(input int max_cyc, input int stop_wr);
        int n;
        n = 0;
        forever begin
            if (stop_wr > 0 && wr_hs >= stop_wr) return;
            if (stop_wr == 0 && all_idle()) return;
            if (n >= max_cyc) begin
                tmo++;
                $display("run bound of %0d cycles expired", max_cyc);
                return;
            end
            cycle_step();
            n++;
        end
    endtask

    task automatic issue(input tx_t t, input logic [15:0] rd_base);
        stim_q.push_back(t);
        expect_tx(t, rd_base);
    endtask

    tx_t a0, a1, b0, b1;

    initial begin
        rst = 1'b0;
        clear_bfm();
        s_read_ready = 2'b11;
        m_req_ready  = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Both ports contend twice in a row
        a0 = mk(0, 1, 0, 32'h0000_0100, 14'd0, 16'h2001, 2'b01);
        a1 = mk(0, 1, 0, 32'h0000_0104, 14'd0, 16'h2002, 2'b01);
        b0 = mk(1, 1, 0, 32'h0000_0200, 14'd0, 16'h3001, 2'b10);
        b1 = mk(1, 1, 0, 32'h0000_0204, 14'd0, 16'h3002, 2'b10);
        stim_q.push_back(a0); stim_q.push_back(a1);
        stim_q.push_back(b0); stim_q.push_back(b1);
`ifdef MAM_ARB_FIXED_PRIO_EN
        expect_tx(a0, 16'h0); expect_tx(a1, 16'h0); expect_tx(b0, 16'h0); expect_tx(b1, 16'h0);
`else
        expect_tx(a0, 16'h0); expect_tx(b0, 16'h0); expect_tx(a1, 16'h0); expect_tx(b1, 16'h0);
`endif
        run(200, 0);
        repeat (2) cycle_step();

        // Port 0 single write; beat field 5 must be ignored without burst
        issue(mk(0, 1, 0, 32'h0000_0000, 14'd5, 16'h000f, 2'b11), 16'h0);
        run(100, 0);
        repeat (2) cycle_step();

        // Port 1 six-beat burst write with the memory stalling 25 cycles
        issue(mk(1, 1, 1, 32'h8000_0040, 14'd6, 16'h1100, 2'b10), 16'h0);
        stall = 25;
        drive();
        run(300, 0);
        repeat (2) cycle_step();

        // Port 0 four-beat burst read while port 1 waits with a single read
        mem_rd_data = 16'hA000;
        drive();
        issue(mk(0, 0, 1, 32'h0000_1000, 14'd4, 16'h0, 2'b00), 16'hA000);
        issue(mk(1, 0, 0, 32'h0000_0020, 14'd0, 16'h0, 2'b00), 16'hA004);
        run(200, 0);
        repeat (2) cycle_step();

        // Zero-length burst
        issue(mk(1, 1, 1, 32'h0000_0044, 14'd0, 16'h7777, 2'b11), 16'h0);
        run(100, 0);
        repeat (2) cycle_step();

        // Reset during beat 3 of a six-beat write, then a fresh read
        issue(mk(0, 1, 1, 32'h0000_9000, 14'd6, 16'h5500, 2'b01), 16'h0);
        run(200, 2);
        #2 rst = 1'b0;
        clear_bfm();
        drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mem_rd_data = 16'hB000;
        drive();
        issue(mk(1, 0, 0, 32'h0000_0077, 14'd0, 16'h0, 2'b00), 16'hB000);
        run(100, 0);
        repeat (3) cycle_step();

        end_req = 1;
        for (int i = 0; i < 20 && !end_ack; i++) @(posedge clk);
        if (!end_ack) $display("FAIL end_handshake: got=0 expected=1");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
